// File: rtl/reg_addr_demux.sv
// Register-bus address demultiplexer: decodes one master request against an address map and
// forwards it to a single slave. Define REG_DEMUX_TIMEOUT_EN to bound the FWD wait.
module reg_addr_demux #(
   parameter int unsigned NumSlaves     = 4,
   parameter int unsigned NumRules      = 4,
   parameter int unsigned AddrWidth     = 64,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned TimeoutCycles = 256
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [NumRules*(32+2*AddrWidth)-1:0] addr_map_i,
   input  logic                              mst_valid_i,
   input  logic                              mst_write_i,
   input  logic [AddrWidth-1:0]              mst_addr_i,
   input  logic [DataWidth-1:0]              mst_wdata_i,
   input  logic [DataWidth/8-1:0]            mst_wstrb_i,
   output logic                              mst_ready_o,
   output logic                              mst_error_o,
   output logic [DataWidth-1:0]              mst_rdata_o,
   output logic [NumSlaves-1:0]              slv_valid_o,
   output logic                              slv_write_o,
   output logic [AddrWidth-1:0]              slv_addr_o,
   output logic [DataWidth-1:0]              slv_wdata_o,
   output logic [DataWidth/8-1:0]            slv_wstrb_o,
   input  logic [NumSlaves-1:0]              slv_ready_i,
   input  logic [NumSlaves-1:0]              slv_error_i,
   input  logic [NumSlaves*DataWidth-1:0]    slv_rdata_i,
   output logic                              busy_o,
   output logic [15:0]                       err_cnt_o
);

   localparam int unsigned RuleW = 32 + 2*AddrWidth;
   localparam int unsigned SelW  = (NumSlaves > 1) ? $clog2(NumSlaves) : 1;

   if (NumSlaves < 1 || NumSlaves > 16 || TimeoutCycles < 1) begin : g_param_check
      $error("reg_addr_demux: NumSlaves must be 1..16 and TimeoutCycles >= 1");
   end

   typedef enum logic [1:0] {IDLE, FWD, RESP, ERR} state_e;

   state_e               state_q, state_d;
   logic [SelW-1:0]      sel_q;
   logic [DataWidth-1:0] rdata_q;
   logic                 err_q;
   logic [15:0]          err_cnt_q;
   logic                 tmo_expire;

   logic                 hit;
   logic                 matched;
   logic [SelW-1:0]      hit_sel;
   logic [31:0]          rule_idx;
   logic [AddrWidth-1:0] rule_start, rule_end;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Lowest-numbered matching rule wins; an empty or inverted range never matches.
   always_comb begin
      hit        = 1'b0;
      matched    = 1'b0;
      hit_sel    = '0;
      rule_idx   = '0;
      rule_start = '0;
      rule_end   = '0;
      for (int r = 0; r < NumRules; r++) begin
         rule_idx   = addr_map_i[r*RuleW + 2*AddrWidth +: 32];
         rule_start = addr_map_i[r*RuleW + AddrWidth +: AddrWidth];
         rule_end   = addr_map_i[r*RuleW +: AddrWidth];
         if (!matched && (rule_start < rule_end) &&
             (mst_addr_i >= rule_start) && (mst_addr_i < rule_end)) begin
            matched = 1'b1;
            if (rule_idx < NumSlaves) begin
               hit     = 1'b1;
               hit_sel = rule_idx[SelW-1:0];
            end
         end
      end
   end

`ifdef REG_DEMUX_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

   logic [TmoW-1:0] tmo_q;

   // Slave ready in the expiry cycle wins over the timeout.
   assign tmo_expire = (state_q == FWD) && !slv_ready_i[sel_q] && (tmo_q == TmoLast);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tmo_q <= '0;
      end else if (state_q == FWD && !slv_ready_i[sel_q] && !tmo_expire) begin
         tmo_q <= tmo_q + 1'b1;
      end else begin
         tmo_q <= '0;
      end
   end
`else
   assign tmo_expire = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (mst_valid_i) state_d = hit ? FWD : ERR;
         FWD:  if (slv_ready_i[sel_q] || tmo_expire) state_d = RESP;
         RESP: state_d = IDLE;
         ERR:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Request copy and slave selection are captured only at the IDLE decode edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sel_q       <= '0;
         slv_write_o <= 1'b0;
         slv_addr_o  <= '0;
         slv_wdata_o <= '0;
         slv_wstrb_o <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (mst_valid_i && hit) begin
                  sel_q       <= hit_sel;
                  slv_write_o <= mst_write_i;
                  slv_addr_o  <= mst_addr_i;
                  slv_wdata_o <= mst_wdata_i;
                  slv_wstrb_o <= mst_wstrb_i;
               end else if (mst_valid_i) begin
                  err_cnt_q <= sat_inc(err_cnt_q);
               end
            end
            FWD: begin
               if (slv_ready_i[sel_q]) begin
                  rdata_q <= slv_rdata_i[sel_q*DataWidth +: DataWidth];
                  err_q   <= slv_error_i[sel_q];
               end else if (tmo_expire) begin
                  rdata_q   <= '0;
                  err_q     <= 1'b1;
                  err_cnt_q <= sat_inc(err_cnt_q);
               end
            end
            default: ;
         endcase
      end
   end

   // All master/slave handshake outputs decode from state, so reset clears them at once.
   always_comb begin
      slv_valid_o = '0;
      if (state_q == FWD) slv_valid_o[sel_q] = 1'b1;
   end

   assign mst_ready_o = (state_q == RESP) || (state_q == ERR);
   assign mst_error_o = (state_q == ERR) || ((state_q == RESP) && err_q);
   assign mst_rdata_o = (state_q == RESP) ? rdata_q : '0;
   assign busy_o      = (state_q != IDLE);
   assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_reg_addr_demux.sv
// Randomized self-checking bench for reg_addr_demux with a rule-table reference decoder.
module tb_reg_addr_demux;

   localparam int NS  = 4;
   localparam int NR  = 4;
   localparam int AW  = 64;
   localparam int DW  = 32;
   localparam int TMO = 8;
   localparam int RW  = 32 + 2*AW;

   typedef struct packed {
      logic [31:0] idx;
      logic [63:0] lo;
      logic [63:0] hi;
   } rule_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic [NR*RW-1:0]  addr_map;
   logic              mst_valid, mst_write;
   logic [AW-1:0]     mst_addr;
   logic [DW-1:0]     mst_wdata;
   logic [DW/8-1:0]   mst_wstrb;
   logic              mst_ready, mst_error;
   logic [DW-1:0]     mst_rdata;
   logic [NS-1:0]     slv_valid;
   logic              slv_write;
   logic [AW-1:0]     slv_addr;
   logic [DW-1:0]     slv_wdata;
   logic [DW/8-1:0]   slv_wstrb;
   logic [NS-1:0]     slv_ready, slv_error;
   logic [NS*DW-1:0]  slv_rdata;
   logic              busy;
   logic [15:0]       err_cnt;

   reg_addr_demux #(
      .NumSlaves(NS), .NumRules(NR), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TMO)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .addr_map_i(addr_map),
      .mst_valid_i(mst_valid), .mst_write_i(mst_write), .mst_addr_i(mst_addr),
      .mst_wdata_i(mst_wdata), .mst_wstrb_i(mst_wstrb),
      .mst_ready_o(mst_ready), .mst_error_o(mst_error), .mst_rdata_o(mst_rdata),
      .slv_valid_o(slv_valid), .slv_write_o(slv_write), .slv_addr_o(slv_addr),
      .slv_wdata_o(slv_wdata), .slv_wstrb_o(slv_wstrb),
      .slv_ready_i(slv_ready), .slv_error_i(slv_error), .slv_rdata_i(slv_rdata),
      .busy_o(busy), .err_cnt_o(err_cnt)
   );

   int passed = 0;
   int total  = 0;
   rule_t rules[NR];
   logic [15:0] exp_err;

   int          o_lat, o_vcyc, o_proto;
   logic [31:0] o_rd, o_wd;
   logic        o_er, o_w, o_idle_ok;
   logic [3:0]  o_seen, o_ws;
   logic [63:0] o_addr;

   task automatic load_map();
      for (int r = 0; r < NR; r++) addr_map[r*RW +: RW] = rules[r];
   endtask

   task automatic set_base_map();
      rules[0] = '{32'd0, 64'h1000_0000, 64'h1000_1000};
      rules[1] = '{32'd1, 64'h1000_1000, 64'h1000_2000};
      rules[2] = '{32'd2, 64'h4000_0000, 64'h3000_0000};  // inverted: never matches
      rules[3] = '{32'd7, 64'h3000_0000, 64'h3000_1000};  // slave index out of range
      load_map();
   endtask

   task automatic set_overlap_map();
      rules[0] = '{32'd0, 64'h1000_0000, 64'h1000_1000};
      rules[1] = '{32'd1, 64'h1000_1000, 64'h1000_2000};
      rules[2] = '{32'd3, 64'h1000_0000, 64'h1000_0100};
      rules[3] = '{32'd2, 64'h5000_0000, 64'h5000_1000};
      load_map();
   endtask

   // Reference decoder: first rule whose non-empty range contains the address.
   function automatic int ref_decode(input logic [63:0] a);
      for (int r = 0; r < NR; r++)
         if (rules[r].lo < rules[r].hi && a >= rules[r].lo && a < rules[r].hi)
            return (rules[r].idx < NS) ? int'(rules[r].idx) : -1;
      return -1;
   endfunction

   task automatic idle_slaves();
      for (int s = 0; s < NS; s++) begin
         slv_ready[s] = 1'b1;
         slv_error[s] = 1'b1;
         slv_rdata[s*DW +: DW] = 32'hDEAD_0000 | s;
      end
   endtask

   // Master driver plus responding slave; observations land in the o_* variables.
   task automatic xfer(input logic [63:0] a, input logic w, input logic [31:0] wd,
                       input logic [3:0] ws, input int dly, input logic [31:0] rd,
                       input logic er, input int budget, input bit clobber);
      @(negedge clk);
      mst_valid = 1'b1; mst_write = w; mst_addr = a; mst_wdata = wd; mst_wstrb = ws;
      o_lat = -1; o_vcyc = 0; o_proto = 0; o_seen = '0; o_rd = '0; o_er = 1'b0;
      o_idle_ok = 1'b0; o_addr = '0; o_w = 1'b0; o_wd = '0; o_ws = '0;
      for (int n = 1; n <= budget && o_lat < 0; n++) begin
         @(posedge clk); #1;
         if (clobber && n == 1) addr_map = '0;
         if (slv_valid != '0) begin
            o_vcyc++;
            o_seen |= slv_valid;
            if (o_vcyc == 1) begin
               o_addr = slv_addr; o_w = slv_write; o_wd = slv_wdata; o_ws = slv_wstrb;
            end
         end
         for (int s = 0; s < NS; s++) begin
            if (slv_valid[s]) begin
               slv_ready[s] = (o_vcyc > dly);
               slv_error[s] = er;
               slv_rdata[s*DW +: DW] = rd;
            end else begin
               slv_ready[s] = 1'b1;
               slv_error[s] = 1'b1;
               slv_rdata[s*DW +: DW] = 32'hDEAD_0000 | s;
            end
         end
         if (mst_ready) begin
            o_lat = n; o_rd = mst_rdata; o_er = mst_error;
         end else if (mst_rdata != '0 || mst_error) begin
            o_proto++;
         end
      end
      if (o_lat >= 0) begin
         @(posedge clk); #1;
         o_idle_ok = !mst_ready && !busy && (slv_valid == '0);
      end
      mst_valid = 1'b0;
      idle_slaves();
      if (clobber) load_map();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mst_valid = 1'b0; mst_write = 1'b0; mst_addr = '0;
      mst_wdata = '0; mst_wstrb = '0;
      idle_slaves();
      set_base_map();
      exp_err = '0;
      #12;
      total++; if ({mst_ready, mst_error, mst_rdata, slv_valid, busy, err_cnt} !== '0)
         $display("FAIL reset_outputs: got rdy=%b err=%b rd=%h sv=%b busy=%b cnt=%h required all 0",
                  mst_ready, mst_error, mst_rdata, slv_valid, busy, err_cnt); else passed++;
      total++; if ({slv_write, slv_addr, slv_wdata, slv_wstrb} !== '0)
         $display("FAIL reset_req_copy: got addr=%h wd=%h required 0", slv_addr, slv_wdata); else passed++;
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_basic_hit();
      xfer(64'h1000_1004, 1'b0, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 1'b0, 10, 1'b0);
      total++; if (o_seen !== 4'b0010) $display("FAIL hit_valid: got %b required 0010", o_seen); else passed++;
      total++; if (o_vcyc !== 1) $display("FAIL hit_vcyc: got %0d required 1", o_vcyc); else passed++;
      total++; if (o_lat !== 2) $display("FAIL hit_latency: got %0d required 2", o_lat); else passed++;
      total++; if (o_rd !== 32'hCAFE_F00D) $display("FAIL hit_rdata: got %h required cafef00d", o_rd); else passed++;
      total++; if (o_er !== 1'b0) $display("FAIL hit_error: got %b required 0", o_er); else passed++;
      total++; if (o_proto !== 0 || !o_idle_ok)
         $display("FAIL hit_idle_gating: got viol=%0d idle=%b required 0/1", o_proto, o_idle_ok); else passed++;
   endtask

   task automatic test_miss();
      logic [63:0] addrs[3];
      addrs[0] = 64'h2000_0000;   // no rule
      addrs[1] = 64'h4000_0000;   // inside inverted rule only
      addrs[2] = 64'h3000_0800;   // rule with out-of-range slave index
      for (int i = 0; i < 3; i++) begin
         xfer(addrs[i], 1'b0, 32'h0, 4'h0, 0, 32'h1234_5678, 1'b0, 10, 1'b0);
         exp_err = exp_err + 16'd1;
         total++; if (o_lat !== 1 || o_er !== 1'b1 || o_rd !== '0)
            $display("FAIL miss_resp[%0d]: got lat=%0d err=%b rd=%h required 1/1/0", i, o_lat, o_er, o_rd); else passed++;
         total++; if (o_seen !== 4'b0000) $display("FAIL miss_no_valid[%0d]: got %b required 0000", i, o_seen); else passed++;
         total++; if (err_cnt !== exp_err) $display("FAIL miss_err_cnt[%0d]: got %h required %h", i, err_cnt, exp_err); else passed++;
      end
   endtask

   task automatic test_overlap();
      set_overlap_map();
      xfer(64'h1000_0010, 1'b1, 32'h0BAD_BEEF, 4'hF, 1, 32'h5555_AAAA, 1'b0, 10, 1'b0);
      total++; if (o_seen !== 4'b0001) $display("FAIL overlap_sel: got %b required 0001", o_seen); else passed++;
      total++; if (o_lat !== 3 || o_rd !== 32'h5555_AAAA)
         $display("FAIL overlap_resp: got lat=%0d rd=%h required 3/5555aaaa", o_lat, o_rd); else passed++;
      set_base_map();
   endtask

   task automatic test_random();
      logic [63:0] a, span;
      logic [31:0] rd, wd;
      logic        w, er;
      logic [3:0]  ws;
      int          dly, e, pick;
      for (int m = 0; m < 2; m++) begin
         if (m == 0) set_base_map(); else set_overlap_map();
         for (int t = 0; t < 25; t++) begin
            pick = $urandom_range(0, NR);
            if (pick < NR) begin
               span = (rules[pick].hi > rules[pick].lo) ? rules[pick].hi - rules[pick].lo : 64'h100;
               a = rules[pick].lo + ({$urandom, $urandom} % span);
            end else begin
               a = {$urandom, $urandom};
            end
            w = 1'($urandom); wd = $urandom; ws = 4'($urandom); rd = $urandom;
            er = ($urandom_range(0, 3) == 0); dly = $urandom_range(0, 3);
            e = ref_decode(a);
            xfer(a, w, wd, ws, dly, rd, er, dly + 10, 1'b0);
            total++; if (o_proto !== 0 || !o_idle_ok)
               $display("FAIL rnd_gating[%0d.%0d]: got viol=%0d idle=%b required 0/1", m, t, o_proto, o_idle_ok); else passed++;
            if (e < 0) begin
               exp_err = (exp_err == 16'hFFFF) ? exp_err : exp_err + 16'd1;
               total++; if (o_lat !== 1 || o_er !== 1'b1 || o_rd !== '0 || o_seen !== '0)
                  $display("FAIL rnd_miss[%0d.%0d]: got lat=%0d err=%b rd=%h sv=%b required 1/1/0/0",
                           m, t, o_lat, o_er, o_rd, o_seen); else passed++;
            end else begin
               total++; if (o_seen !== (4'b1 << e) || o_vcyc !== dly + 1 || o_lat !== dly + 2)
                  $display("FAIL rnd_hit_timing[%0d.%0d]: got sv=%b vcyc=%0d lat=%0d required %b/%0d/%0d",
                           m, t, o_seen, o_vcyc, o_lat, 4'b1 << e, dly + 1, dly + 2); else passed++;
               total++; if (o_rd !== rd || o_er !== er)
                  $display("FAIL rnd_hit_resp[%0d.%0d]: got rd=%h err=%b required %h/%b", m, t, o_rd, o_er, rd, er); else passed++;
               total++; if (o_addr !== a || o_w !== w || o_wd !== wd || o_ws !== ws)
                  $display("FAIL rnd_req_copy[%0d.%0d]: got a=%h w=%b wd=%h ws=%h required %h/%b/%h/%h",
                           m, t, o_addr, o_w, o_wd, o_ws, a, w, wd, ws); else passed++;
            end
            total++; if (err_cnt !== exp_err)
               $display("FAIL rnd_err_cnt[%0d.%0d]: got %h required %h", m, t, err_cnt, exp_err); else passed++;
         end
      end
      set_base_map();
   endtask

   task automatic test_map_stable();
      xfer(64'h1000_0040, 1'b0, 32'h0, 4'h0, 2, 32'h7777_1111, 1'b0, 12, 1'b1);
      total++; if (o_seen !== 4'b0001 || o_lat !== 4 || o_rd !== 32'h7777_1111 || o_er !== 1'b0)
         $display("FAIL map_change_inflight: got sv=%b lat=%0d rd=%h err=%b required 0001/4/77771111/0",
                  o_seen, o_lat, o_rd, o_er); else passed++;
   endtask

   task automatic test_timeout();
`ifdef REG_DEMUX_TIMEOUT_EN
      xfer(64'h1000_1010, 1'b0, 32'h0, 4'h0, 1000, 32'hFFFF_FFFF, 1'b0, 40, 1'b0);
      exp_err = (exp_err == 16'hFFFF) ? exp_err : exp_err + 16'd1;
      total++; if (o_vcyc !== TMO || o_lat !== TMO + 1)
         $display("FAIL timeout_timing: got vcyc=%0d lat=%0d required %0d/%0d", o_vcyc, o_lat, TMO, TMO + 1); else passed++;
      total++; if (o_er !== 1'b1 || o_rd !== '0 || err_cnt !== exp_err)
         $display("FAIL timeout_resp: got err=%b rd=%h cnt=%h required 1/0/%h", o_er, o_rd, err_cnt, exp_err); else passed++;
`else
      xfer(64'h1000_1010, 1'b0, 32'h0, 4'h0, 1000, 32'hFFFF_FFFF, 1'b0, 100, 1'b0);
      total++; if (o_lat !== -1 || busy !== 1'b1 || slv_valid !== 4'b0010)
         $display("FAIL no_timeout_wait: got lat=%0d busy=%b sv=%b required -1/1/0010", o_lat, busy, slv_valid); else passed++;
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      exp_err = '0;
`endif
   endtask

   task automatic test_reset_mid_fwd();
      xfer(64'h2000_0000, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b0, 10, 1'b0);
      exp_err = (exp_err == 16'hFFFF) ? exp_err : exp_err + 16'd1;
      @(negedge clk);
      slv_ready = '0;
      mst_valid = 1'b1; mst_write = 1'b0; mst_addr = 64'h1000_1004;
      @(posedge clk); @(posedge clk); #2;
      total++; if (slv_valid !== 4'b0010 || err_cnt !== exp_err)
         $display("FAIL pre_reset_fwd: got sv=%b cnt=%h required 0010/%h", slv_valid, err_cnt, exp_err); else passed++;
      rst_n = 1'b0;
      #1;
      total++; if (slv_valid !== '0 || busy !== 1'b0 || err_cnt !== '0)
         $display("FAIL async_reset: got sv=%b busy=%b cnt=%h required 0/0/0", slv_valid, busy, err_cnt); else passed++;
      mst_valid = 1'b0;
      idle_slaves();
      exp_err = '0;
      @(negedge clk); rst_n = 1'b1;
      xfer(64'h1000_1004, 1'b0, 32'h0, 4'h0, 0, 32'h0123_4567, 1'b0, 10, 1'b0);
      total++; if (o_seen !== 4'b0010 || o_lat !== 2 || o_rd !== 32'h0123_4567)
         $display("FAIL after_reset_xfer: got sv=%b lat=%0d rd=%h required 0010/2/01234567", o_seen, o_lat, o_rd); else passed++;
   endtask

   task automatic test_err_sat();
      @(negedge clk);
      force dut.err_cnt_q = 16'hFFFE;
      @(negedge clk);
      release dut.err_cnt_q;
      exp_err = 16'hFFFE;
      for (int i = 0; i < 3; i++) begin
         xfer(64'h2000_0000, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b0, 10, 1'b0);
         exp_err = (exp_err == 16'hFFFF) ? exp_err : exp_err + 16'd1;
         total++; if (err_cnt !== exp_err)
            $display("FAIL err_cnt_sat[%0d]: got %h required %h", i, err_cnt, exp_err); else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_basic_hit();
      test_miss();
      test_overlap();
      test_random();
      test_map_stable();
      test_timeout();
      test_reset_mid_fwd();
      test_err_sat();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/reg_addr_demux.md
REG_ADDR_DEMUX -- requirements
Module: reg_addr_demux

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  NumSlaves, 4, number of register-bus slave ports (1..16).
  NumRules, 4, number of address-map rules.
  AddrWidth, 64, request address width.
  DataWidth, 32, read/write data width.
  TimeoutCycles, 256, FWD cycles before timeout (>=1); used only when REG_DEMUX_TIMEOUT_EN is defined.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  clk_i  in  1  single clock; all state on rising edge.
  rst_ni  in  1  asynchronous active-low reset.
  addr_map_i  in  NumRules x (32+2*AddrWidth)  rules {idx, start_addr, end_addr}; end exclusive.
  mst_valid_i / mst_write_i  in  1 / 1  master request valid / write flag.
  mst_addr_i  in  AddrWidth  master address.
  mst_wdata_i / mst_wstrb_i  in  DataWidth / DataWidth/8  write data / byte strobes.
  mst_ready_o / mst_error_o  out  1 / 1  transfer-complete pulse / error flag.
  mst_rdata_o  out  DataWidth  read data.
  slv_valid_o  out  NumSlaves  per-slave request valid.
  slv_write_o, slv_addr_o, slv_wdata_o, slv_wstrb_o  out  shared  registered request copy to all slaves.
  slv_ready_i, slv_error_i  in  NumSlaves each  per-slave ready/error.
  slv_rdata_i  in  NumSlaves x DataWidth  per-slave read data.
  busy_o  out  1  high whenever state is not IDLE.
  err_cnt_o  out  16  saturating count of decode errors plus timeouts.

Function
REQ-003 Handshake SHALL be the reg-bus rule: transfer completes in the cycle valid and ready are both high; master holds request stable until then.
REQ-004 FSM states SHALL be IDLE, FWD, RESP, ERR.
REQ-005 In IDLE with mst_valid_i=1, decode SHALL match rule r when start_addr <= addr < end_addr; lowest r wins; rule with start_addr >= end_addr never matches.
REQ-006 Match with idx < NumSlaves SHALL register request and slave index, next state FWD; no match or idx >= NumSlaves SHALL go to ERR.
REQ-007 In FWD, exactly one bit slv_valid_o[sel] SHALL be high, driven from registered request; others low.
REQ-008 In FWD with slv_ready_i[sel]=1, rdata/error SHALL be captured, slave valid dropped next cycle, next state RESP.
REQ-009 RESP SHALL last exactly one cycle: mst_ready_o=1 with captured rdata/error, then IDLE.
REQ-010 ERR SHALL last one cycle: mst_ready_o=1, mst_error_o=1, mst_rdata_o=0, err_cnt_o incremented, then IDLE.
REQ-011 Latency: valid sampled at edge k; hit with slave ready in cycle k+1 SHALL give mst_ready_o in cycle k+2; miss SHALL give mst_ready_o in cycle k+1.
REQ-012 mst_ready_o SHALL be low in IDLE and FWD; a new request SHALL be accepted no earlier than the cycle after RESP/ERR.
REQ-013 mst_rdata_o and mst_error_o SHALL be 0 whenever mst_ready_o=0.
REQ-014 err_cnt_o SHALL saturate at 16'hFFFF.
REQ-015 addr_map_i SHALL be sampled only at the IDLE decode edge; later changes do not affect an in-flight transfer.

Reset
REQ-016 rst_ni low SHALL asynchronously force IDLE, all outputs 0, err_cnt_o=0, timeout counter 0, including mid-FWD (slave valid drops immediately).

Configuration
REQ-017 Macro REG_DEMUX_TIMEOUT_EN defined: counter SHALL count FWD cycles; after TimeoutCycles cycles without slave ready, slave valid drops, next state RESP with mst_error_o=1, rdata=0, err_cnt_o incremented; slave ready in the same cycle as expiry SHALL take priority (normal response).
REQ-018 Macro undefined: no counter; FWD SHALL wait indefinitely for slave ready.

Verification
REQ-019 Rules {0:0x1000_0000-0x1000_1000, 1:0x1000_1000-0x1000_2000}; read 0x1000_1004, slave1 ready at once, rdata 0xCAFE_F00D -> slv_valid_o=4'b0010 one cycle, mst_ready_o two cycles after valid, rdata 0xCAFE_F00D, error 0.
REQ-020 Read 0x2000_0000 (no match) -> mst_ready_o next cycle, error 1, rdata 0, err_cnt_o 0->1, no slv_valid_o bit ever high.
REQ-021 Overlapping rules 0 and 2 both covering 0x1000_0010 -> slave index from rule 0 selected.
REQ-022 Macro defined, TimeoutCycles=8, slave never ready -> slv_valid_o high 8 cycles, then mst_ready_o with error 1; undefined -> busy_o stays high 100 cycles.
REQ-023 Reset asserted in second FWD cycle -> slv_valid_o, busy_o, err_cnt_o 0 without clock edge; next request after release completes normally.
REQ-024 err_cnt_o preloaded to 0xFFFE via 3 misses from forced state -> reads 0xFFFF and holds.
